// File: rtl/vtab_loader.sv
// Vector-table loader: receives NUM_VEC words plus an XOR checksum over valid/ready,
// then publishes and freezes the table and releases core_hold until the next reset.
module vtab_loader #(
    parameter int          NUM_VEC   = 20,
    parameter logic [31:0] CSUM_SEED = 32'hA5A5_A5A5
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic                   load_start,
    input  logic                   cfg_valid,
    input  logic [31:0]            cfg_data,
    output logic                   cfg_ready,
    output logic [NUM_VEC*32-1:0]  vec_table,
    output logic                   vtab_valid,
    output logic                   load_err,
    output logic                   busy,
    output logic                   core_hold
);

    localparam int CNT_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_LOCKED,
        S_ERROR
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [31:0]              csum_q,  csum_d;
    logic [NUM_VEC-1:0][31:0] stage_q, stage_d;
    logic                     beat;

    // A restart request masks ready so the beat presented alongside it is never consumed.
    assign busy       = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign cfg_ready  = busy && !load_start;
    assign beat       = cfg_valid && cfg_ready;
    assign vtab_valid = (state_q == S_LOCKED);
    assign core_hold  = ~vtab_valid;
    assign load_err   = (state_q == S_ERROR);
    assign vec_table  = vtab_valid ? stage_q : '0;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
        state_d = state_q;
        count_d = count_q;
        csum_d  = csum_q;
        stage_d = stage_q;

        if (load_start && (state_q != S_LOCKED)) begin
            state_d = S_LOAD;
            count_d = '0;
            csum_d  = CSUM_SEED;
            stage_d = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (beat) begin
                        stage_d[count_q] = cfg_data;
                        csum_d           = csum_q ^ cfg_data;
                        count_d          = count_q + 1'b1;
                        if (count_q == CNT_W'(NUM_VEC - 1)) begin
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (beat) begin
                        if (cfg_data == csum_q) begin
                            state_d = S_LOCKED;
                        end else begin
                            state_d = S_ERROR;
                            stage_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            csum_q  <= CSUM_SEED;
            // NOTE: the staging array is reset on purpose; a partial table must never survive a reset.
            stage_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
            state_q <= state_d;
            count_q <= count_d;
            csum_q  <= csum_d;
            stage_q <= stage_d;
        end
    end

endmodule

// File: tb/tb_vtab_loader.sv
// Self-checking bench for vtab_loader: each scenario task compares the DUT against
// a reference table and XOR checksum computed directly from the words it sends.
module tb_vtab_loader;

    localparam int          NUM_VEC = 20;
    localparam logic [31:0] SEED    = 32'hA5A5_A5A5;

    logic                  hclk = 1'b0;
    logic                  hreset;
    logic                  load_start;
    logic                  cfg_valid;
    logic [31:0]           cfg_data;
    logic                  cfg_ready;
    logic [NUM_VEC*32-1:0] vec_table;
    logic                  vtab_valid;
    logic                  load_err;
    logic                  busy;
    logic                  core_hold;

    vtab_loader #(.NUM_VEC(NUM_VEC), .CSUM_SEED(SEED)) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .load_start (load_start),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .vec_table  (vec_table),
        .vtab_valid (vtab_valid),
        .load_err   (load_err),
        .busy       (busy),
        .core_hold  (core_hold)
    );

    always #5 hclk = ~hclk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stall_ready_bad = 0;
    logic [31:0] words [NUM_VEC];

    always @(posedge hclk) cyc++;

    function automatic logic [31:0] ref_csum();
        logic [31:0] r = SEED;
        for (int i = 0; i < NUM_VEC; i++) r ^= words[i];
        return r;
    endfunction

    function automatic logic [NUM_VEC*32-1:0] ref_table();
        logic [NUM_VEC*32-1:0] t = '0;
        for (int i = 0; i < NUM_VEC; i++) t[32*i +: 32] = words[i];
        return t;
    endfunction

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic apply_reset();
        hreset = 1'b1; load_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        step();
        hreset = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic scenario_words();
        foreach (words[i]) words[i] = '0;
        words[0] = 32'h2000_1000;
        words[1] = 32'h0000_0101;
    endtask

    task automatic rand_words();
        foreach (words[i]) words[i] = $urandom;
    endtask

    // Presents one word and waits (bounded) for it to be accepted.
    task automatic send_word(input logic [31:0] w, input bit stall);
        bit hs = 1'b0;
        if (stall) begin
            cfg_valid = 1'b0;
            cfg_data  = $urandom;
            #1;
            if (cfg_ready !== 1'b1) stall_ready_bad++;
            step();
        end
        cfg_valid = 1'b1;
        cfg_data  = w;
        for (int n = 0; n < 8 && !hs; n++) begin
            #1;
            hs = (cfg_ready === 1'b1);
            step();
        end
        if (!hs) begin
            checks++; failures++;
            $display("FAIL handshake_timeout: word %h not accepted, cfg_ready=%b required 1", w, cfg_ready);
        end
    endtask

    task automatic load_table(input bit stall, input logic [31:0] csum_word);
        for (int i = 0; i < NUM_VEC; i++) send_word(words[i], stall);
        send_word(csum_word, stall);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({cfg_ready, vtab_valid, load_err, busy, core_hold} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_flags: got rdy/val/err/busy/hold=%b required 00001",
                     {cfg_ready, vtab_valid, load_err, busy, core_hold});
        end
        checks++;
        if (vec_table !== '0) begin
            failures++;
            $display("FAIL reset_table: got %h required 0", vec_table);
        end
        cfg_valid = 1'b1; cfg_data = $urandom;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready: got %b required 0", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_good_load();
        int s;
        apply_reset();
        scenario_words();
        pulse_start();
        s = cyc;
        for (int i = 0; i < NUM_VEC; i++) send_word(words[i], 1'b0);
        checks++;
        if (vtab_valid !== 1'b0 || core_hold !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_check_state: got val=%b hold=%b busy=%b required 0 1 1", vtab_valid, core_hold, busy);
        end
        send_word(32'h85A5_B4A4, 1'b0);
        cfg_valid = 1'b0;
        checks++;
        if (vtab_valid !== 1'b1 || core_hold !== 1'b0 || (cyc - s) != NUM_VEC + 1) begin
            failures++;
            $display("FAIL lock_timing: got val=%b hold=%b edges=%0d required 1 0 %0d",
                     vtab_valid, core_hold, cyc - s, NUM_VEC + 1);
        end
        checks++;
        if (vec_table[31:0] !== 32'h2000_1000 || vec_table[63:32] !== 32'h0000_0101) begin
            failures++;
            $display("FAIL sp_reset_vec: got %h %h required 20001000 00000101", vec_table[31:0], vec_table[63:32]);
        end
        checks++;
        if (vec_table !== ref_table() || load_err !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL locked_outputs: table=%h err=%b busy=%b rdy=%b required table=%h 0 0 0",
                     vec_table, load_err, busy, cfg_ready, ref_table());
        end
    endtask

    task automatic test_random_loads();
        for (int k = 0; k < 3; k++) begin
            apply_reset();
            rand_words();
            pulse_start();
            load_table(1'b0, ref_csum());
            checks++;
            if (vtab_valid !== 1'b1 || vec_table !== ref_table()) begin
                failures++;
                $display("FAIL random_load_%0d: val=%b table=%h required 1 %h", k, vtab_valid, vec_table, ref_table());
            end
        end
    endtask

    task automatic test_bad_csum();
        apply_reset();
        scenario_words();
        pulse_start();
        load_table(1'b0, 32'h0000_0000);
        checks++;
        if ({load_err, vtab_valid, core_hold, busy, cfg_ready} !== 5'b10100 || vec_table !== '0) begin
            failures++;
            $display("FAIL bad_csum: err/val/hold/busy/rdy=%b table=%h required 10100 0",
                     {load_err, vtab_valid, core_hold, busy, cfg_ready}, vec_table);
        end
        rand_words();
        pulse_start();
        checks++;
        if (load_err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL err_restart: err=%b busy=%b required 0 1", load_err, busy);
        end
        load_table(1'b0, ref_csum() ^ (32'h1 << $urandom_range(31)));
        checks++;
        if (load_err !== 1'b1 || vtab_valid !== 1'b0) begin
            failures++;
            $display("FAIL bitflip_csum: err=%b val=%b required 1 0", load_err, vtab_valid);
        end
        rand_words();
        pulse_start();
        load_table(1'b0, ref_csum());
        checks++;
        if (vtab_valid !== 1'b1 || load_err !== 1'b0 || vec_table !== ref_table()) begin
            failures++;
            $display("FAIL reload_after_err: val=%b err=%b table=%h required 1 0 %h",
                     vtab_valid, load_err, vec_table, ref_table());
        end
    endtask

    task automatic test_stall();
        int s;
        apply_reset();
        scenario_words();
        stall_ready_bad = 0;
        pulse_start();
        s = cyc;
        load_table(1'b1, 32'h85A5_B4A4);
        checks++;
        if ((cyc - s) != 2 * (NUM_VEC + 1) || stall_ready_bad != 0) begin
            failures++;
            $display("FAIL stall_timing: edges=%0d ready_drops=%0d required %0d 0",
                     cyc - s, stall_ready_bad, 2 * (NUM_VEC + 1));
        end
        checks++;
        if (vtab_valid !== 1'b1 || vec_table !== ref_table()) begin
            failures++;
            $display("FAIL stall_table: val=%b table=%h required 1 %h", vtab_valid, vec_table, ref_table());
        end
    endtask

    task automatic test_restart();
        apply_reset();
        rand_words();
        pulse_start();
        for (int i = 0; i < 7; i++) send_word(words[i], 1'b0);
        load_start = 1'b1; cfg_valid = 1'b1; cfg_data = $urandom;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL restart_ready: got %b required 0", cfg_ready);
        end
        step();
        load_start = 1'b0; cfg_valid = 1'b0;
        // Second restart lands in the checksum phase.
        rand_words();
        for (int i = 0; i < NUM_VEC; i++) send_word(words[i], 1'b0);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || vtab_valid !== 1'b0) begin
            failures++;
            $display("FAIL restart_check: busy=%b val=%b required 1 0", busy, vtab_valid);
        end
        rand_words();
        load_table(1'b0, ref_csum());
        checks++;
        if (vtab_valid !== 1'b1 || vec_table !== ref_table()) begin
            failures++;
            $display("FAIL restart_table: val=%b table=%h required 1 %h", vtab_valid, vec_table, ref_table());
        end
    endtask

    task automatic test_locked_ignore();
        int bad_ready = 0;
        load_start = 1'b1; cfg_valid = 1'b1; cfg_data = $urandom;
        #1;
        if (cfg_ready !== 1'b0) bad_ready++;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_data = $urandom;
            #1;
            if (cfg_ready !== 1'b0) bad_ready++;
            step();
        end
        cfg_valid = 1'b0;
        checks++;
        if (bad_ready != 0 || vtab_valid !== 1'b1 || busy !== 1'b0 || vec_table !== ref_table()) begin
            failures++;
            $display("FAIL locked_frozen: ready_hits=%0d val=%b busy=%b table=%h required 0 1 0 %h",
                     bad_ready, vtab_valid, busy, vec_table, ref_table());
        end
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        rand_words();
        pulse_start();
        for (int i = 0; i < 10; i++) send_word(words[i], 1'b0);
        hreset = 1'b1; cfg_valid = 1'b0;
        step();
        hreset = 1'b0;
        checks++;
        if ({cfg_ready, vtab_valid, load_err, busy, core_hold} !== 5'b00001 || vec_table !== '0) begin
            failures++;
            $display("FAIL midload_reset: rdy/val/err/busy/hold=%b table=%h required 00001 0",
                     {cfg_ready, vtab_valid, load_err, busy, core_hold}, vec_table);
        end
        rand_words();
        pulse_start();
        load_table(1'b0, ref_csum());
        checks++;
        if (vtab_valid !== 1'b1 || vec_table !== ref_table()) begin
            failures++;
            $display("FAIL midload_reload: val=%b table=%h required 1 %h", vtab_valid, vec_table, ref_table());
        end
    endtask

    initial begin
        hreset = 1'b1; load_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        test_reset();
        test_good_load();
        test_random_loads();
        test_bad_csum();
        test_stall();
        test_restart();
        test_locked_ignore();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vtab_loader.md
Name: vtab_loader

Overview:
- Configuration sequencer for the vector-table read-only slave.
- Accepts the vector table as a stream of NUM_VEC 32-bit words plus one trailing checksum word over a valid/ready interface. Entry order: SP, RESET, NMI, FAULT, IRQ0..IRQ15.
- Validates the stream, then publishes and locks the table until reset.
- Holds the core in reset (core_hold) until a valid table is locked, so the slave never serves an unvalidated or partial table.

Parameters:
- NUM_VEC, 20, number of 32-bit vector entries per load.
- CSUM_SEED, 32'hA5A5_A5A5, initial value of the running XOR checksum.

Ports:
- hclk  input  1  clock; all logic on rising edge.
- hreset  input  1  synchronous active-high reset.
- load_start  input  1  single-cycle request to begin or restart a load.
- cfg_valid  input  1  cfg_data holds a valid word.
- cfg_data  input  32  vector or checksum word.
- cfg_ready  output  1  loader accepts a word this cycle; a beat transfers when cfg_valid & cfg_ready.
- vec_table  output  NUM_VEC*32  packed table, entry i at [32*i+31:32*i]; all-zero unless vtab_valid.
- vtab_valid  output  1  table checked and locked.
- load_err  output  1  last load failed its checksum.
- busy  output  1  load in progress (LOAD or CHECK).
- core_hold  output  1  keeps the processor in reset; equals ~vtab_valid.

Behaviour:
- Interface decision: one clock `hclk`; reset `hreset` is synchronous and active-high. Polarity and synchronicity are fixed.
- Reset (hreset=1 at a clock edge):
  - state=IDLE, word count=0, checksum=CSUM_SEED, all staging entries=0.
  - cfg_ready=0, vtab_valid=0, load_err=0, busy=0, core_hold=1, vec_table=0.
- Reset mid-load: discards everything; no partial table is ever visible.
- States: IDLE, LOAD, CHECK, LOCKED, ERROR (one-hot or encoded; implementer's choice).
- IDLE:
  - cfg_ready=0.
  - load_start -> LOAD; clears count, staging and checksum (checksum to CSUM_SEED).
- LOAD:
  - cfg_ready=1, busy=1.
  - Each beat writes cfg_data to staging[count], XORs cfg_data into the checksum, count+1.
  - Beat with count==NUM_VEC-1 -> CHECK.
  - No beat: state and count hold. Stalls of any length are legal.
- CHECK:
  - cfg_ready=1, busy=1.
  - The next beat is the checksum word; it is not stored.
  - If it equals the running checksum -> LOCKED. Otherwise -> ERROR, and staging is cleared to 0 on the same edge.
- LOCKED:
  - vtab_valid=1, core_hold=0, cfg_ready=0.
  - vec_table = staging.
  - load_start is ignored; the table stays frozen until hreset.
- ERROR:
  - load_err=1, cfg_ready=0, core_hold=1.
  - load_start -> LOAD. load_err clears on that edge.
- Restart during a load: load_start in LOAD or CHECK restarts the load (count=0, checksum=CSUM_SEED, staging cleared). The load_start request takes priority over any beat presented in that cycle; that beat is not consumed, because cfg_ready is forced to 0 in any cycle with load_start=1.
- Timing:
  - vtab_valid and core_hold change on the edge that accepts the checksum beat, i.e. first visible in the cycle after the handshake.
  - Minimum load = 1 (start) + NUM_VEC + 1 beats; vtab_valid is high at cycle NUM_VEC+2 after load_start with cfg_valid held high.
- Count width: $clog2(NUM_VEC); wrap beyond NUM_VEC-1 is unreachable because LOAD exits at NUM_VEC-1.
- All outputs are registered or decoded from the state and staging registers only; there is no combinational path from cfg_data to any output.
- cfg_ready depends on state and load_start only; it never depends on cfg_valid.

Test Plan:
1. Reset, then load_start. Words: word0=32'h2000_1000, word1=32'h0000_0101, remaining 18 words=0, then checksum 32'h85A5_B4A4, cfg_valid held high. Required: vtab_valid=1 and core_hold=0 at cycle 22 after load_start; vec_table[31:0]=32'h2000_1000, vec_table[63:32]=32'h0000_0101.
2. Same data but checksum 32'h0000_0000. Required: load_err=1, vtab_valid=0, vec_table=0, core_hold=1. Then a correct reload reaches LOCKED and load_err=0.
3. Same as scenario 1 but cfg_valid toggles 1/0 every cycle. Required: identical final table; cfg_ready=1 throughout LOAD/CHECK; vtab_valid is delayed by the stall cycles only.
4. load_start pulsed after 7 beats, with cfg_valid=1 in the same cycle. Required: that beat is not accepted, count restarts at 0, staging is cleared. The next 20+1 beats load correctly.
5. In LOCKED, pulse load_start and drive cfg_valid with garbage. Required: cfg_ready=0 and the table is unchanged.
6. Assert hreset during LOAD after 10 beats. Required: next cycle state=IDLE, all outputs at reset values, and a full reload succeeds.
